// File: rtl/cn_msg_expander.sv
// Check-node output stage: expands a compressed min-sum result into Wc sign-magnitude
// edge messages, streamed P per beat. Optional macro OFFSET_MS_EN enables offset min-sum.
module cn_msg_expander #(
  parameter int W      = 6,
  parameter int Wc     = 32,
  parameter int P      = 8,
  parameter int OFFSET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-2:0]     in_min1,
  input  logic [W-2:0]     in_min2,
  input  logic [4:0]       in_idx,
  input  logic [Wc-1:0]    in_signs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P*W-1:0]   out_msg,
  output logic [1:0]       out_beat,
  output logic             out_last
);

  localparam int NBEATS = Wc / P;
  localparam logic [W-2:0] OFF = (W-1)'(OFFSET);
`ifdef OFFSET_MS_EN
  localparam bit OFS_EN = 1'b1;
`else
  localparam bit OFS_EN = 1'b0;
`endif

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state, state_nx;
  logic [1:0]     beat, beat_nx;
  logic [W-2:0]   min1_q, min2_q;
  logic [4:0]     idx_q;
  logic [Wc-1:0]  signs_q;
  logic           parity_q;
  logic           last, accept;
  logic [P-1:0]   beat_signs;
  logic [P*W-1:0] slot_msg;

  assign last   = (state == STREAM) && (beat == 2'(NBEATS-1));
  // Ready in STREAM only on the accepted last beat, giving bubble-free back-to-back packets.
  assign in_ready = rst && ((state == IDLE) || (last && out_ready));
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      beat     <= '0;
      min1_q   <= '0;
      min2_q   <= '0;
      idx_q    <= '0;
      signs_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      if (accept) begin
        min1_q   <= in_min1;
        min2_q   <= in_min2;
        idx_q    <= in_idx;
        signs_q  <= in_signs;
        parity_q <= ^in_signs;
      end
    end
  end

  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = STREAM;
          beat_nx  = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last) begin
            beat_nx = '0;
            if (!accept) state_nx = IDLE;
          end else begin
            beat_nx = beat + 2'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        beat_nx  = '0;
      end
    endcase
  end

  assign beat_signs = P'(signs_q >> (32'(beat) * 32'(P)));

  for (genvar j = 0; j < P; j++) begin : g_slot
    logic [31:0]  edge_no;
    logic [W-2:0] mag_raw, mag;
    assign edge_no = 32'(beat) * 32'(P) + 32'(j);
    assign mag_raw = (edge_no == 32'(idx_q)) ? min2_q : min1_q;
    assign mag     = !OFS_EN ? mag_raw : ((mag_raw < OFF) ? '0 : mag_raw - OFF);
    assign slot_msg[j*W +: W] = {parity_q ^ beat_signs[j], mag};
  end

  always_comb begin
    out_valid = (state == STREAM);
    out_last  = last;
    out_beat  = (state == STREAM) ? beat : '0;
    out_msg   = (state == STREAM) ? slot_msg : '0;
  end

endmodule

// File: tb/tb_cn_msg_expander.sv
// Directed table-driven bench for cn_msg_expander (Wc=32 instance plus a Wc=16 instance).
module tb_cn_msg_expander;
  localparam int W = 6;
  localparam int P = 8;
`ifdef OFFSET_MS_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [4:0]  in_min1, in_min2, in_idx;
  logic [31:0] in_signs;
  logic [47:0] out_msg;
  logic [1:0]  out_beat;

  logic        v16, r16, ov16, last16;
  logic [15:0] signs16;
  logic [47:0] msg16;
  logic [1:0]  beat16;

  cn_msg_expander #(.W(6), .Wc(32), .P(8), .OFFSET(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_signs(in_signs),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
    .out_beat(out_beat), .out_last(out_last));

  cn_msg_expander #(.W(6), .Wc(16), .P(8), .OFFSET(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
    .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_signs(signs16),
    .out_valid(ov16), .out_ready(1'b1), .out_msg(msg16),
    .out_beat(beat16), .out_last(last16));

  typedef struct {
    logic [4:0]  m1, m2, ix;
    logic [31:0] sg;
    logic [5:0]  e0;
  } vec_t;

  vec_t tbl[5];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [47:0] model(input vec_t v, input int wc, input int b);
    logic [47:0] r;
    logic [31:0] t;
    logic [4:0]  mag;
    logic        par;
    int          e;
    r   = '0;
    par = 1'b0;
    for (int k = 0; k < wc; k++) begin
      t = v.sg >> k;
      par ^= t[0];
    end
    for (int j = 0; j < P; j++) begin
      e   = b * P + j;
      t   = v.sg >> e;
      mag = (e == int'(v.ix)) ? v.m2 : v.m1;
      if (OFS != 0) mag = (mag >= 5'(OFS)) ? mag - 5'(OFS) : 5'd0;
      r[j*W +: W] = {par ^ t[0], mag};
    end
    return r;
  endfunction

  task automatic drive(input vec_t v);
    in_min1  = v.m1;
    in_min2  = v.m2;
    in_idx   = v.ix;
    in_signs = v.sg;
  endtask

  task automatic send(input vec_t v);
    int k;
    drive(v);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("send_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input vec_t v, input string nm);
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check({nm, "_valid"}, out_valid, 1);
      check({nm, "_beat"}, out_beat, b);
      check({nm, "_last"}, out_last, (b == 3));
      check({nm, "_msg"}, out_msg, model(v, 32, b));
      tick();
    end
    check({nm, "_idle"}, out_valid, 0);
  endtask

  initial begin
    logic [47:0] held;
    vec_t v;
    int k;

    tbl[0] = '{m1: 5'd3,  m2: 5'd9,  ix: 5'd10, sg: 32'h0000_0401, e0: {1'b1, 5'(3 - OFS)}};
    tbl[1] = '{m1: 5'd5,  m2: 5'd7,  ix: 5'd0,  sg: 32'h0000_0001, e0: {1'b0, 5'(7 - OFS)}};
    tbl[2] = '{m1: 5'd6,  m2: 5'd12, ix: 5'd31, sg: 32'h8000_0003, e0: {1'b0, 5'(6 - OFS)}};
    tbl[3] = '{m1: 5'd0,  m2: 5'd2,  ix: 5'd5,  sg: 32'hFFFF_FFFF, e0: {1'b1, 5'd0}};
    tbl[4] = '{m1: 5'd20, m2: 5'd3,  ix: 5'd0,  sg: 32'h8000_0000, e0: {1'b1, 5'(3 - OFS)}};

    v16 = 1'b0;
    signs16 = '0;
    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    drive(tbl[0]);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_msg", out_msg, 0);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_out_beat", out_beat, 0);
    check("idle_out_last", out_last, 0);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i]);
      check("tbl_edge0", out_msg[5:0], tbl[i].e0);
      recv(tbl[i], "tbl");
    end

    // Hand-checked special edges: edge 10 of the basic vector, edge 31 with idx=31.
    send(tbl[0]);
    tick();
    check("basic_edge10", out_msg[17:12], {1'b1, 5'(9 - OFS)});
    check("basic_edge9", out_msg[11:6], {1'b0, 5'(3 - OFS)});
    tick(); tick();
    check("basic_tail_beat", out_beat, 3);
    tick();
    send(tbl[2]);
    tick(); tick(); tick();
    check("idx31_edge31", out_msg[47:42], {1'b0, 5'(12 - OFS)});
    check("idx31_edge30", out_msg[41:36], {1'b1, 5'(6 - OFS)});
    tick();

    // Backpressure during beat 2.
    send(tbl[1]);
    tick(); tick();
    out_ready = 1'b0;
    held = out_msg;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_beat", out_beat, 2);
      check("bp_msg", out_msg, held);
      check("bp_msg_model", out_msg, model(tbl[1], 32, 2));
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_resume_beat", out_beat, 3);
    check("bp_resume_last", out_last, 1);
    tick();
    check("bp_done", out_valid, 0);

    // Back-to-back packets with in_valid held high.
    drive(tbl[3]);
    in_valid = 1'b1;
    check("b2b_first_ready", in_ready, 1);
    tick();
    drive(tbl[4]);
    for (int c = 0; c < 8; c++) begin
      check("b2b_valid", out_valid, 1);
      check("b2b_beat", out_beat, c % 4);
      check("b2b_in_ready", in_ready, (c % 4) == 3);
      check("b2b_msg", out_msg, model((c < 4) ? tbl[3] : tbl[4], 32, c % 4));
      if (c == 7) in_valid = 1'b0;
      tick();
    end
    check("b2b_done", out_valid, 0);

    // Mid-stream reset during beat 1, then a fresh packet.
    send(tbl[2]);
    tick();
    check("mr_beat1", out_beat, 1);
    rst = 1'b0;
    tick();
    check("mr_out_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 0);
    rst = 1'b1;
    send(tbl[3]);
    recv(tbl[3], "mr_next");

    // Wc=16 instance: idx=31 is out of range, every edge carries min1.
    v = '{m1: 5'd4, m2: 5'd11, ix: 5'd31, sg: 32'h0000_8001, e0: '0};
    drive(v);
    signs16 = 16'h8001;
    v16 = 1'b1;
    k = 0;
    while (!r16 && k < 50) begin
      tick();
      k++;
    end
    check("w16_in_ready", r16, 1);
    tick();
    v16 = 1'b0;
    for (int b = 0; b < 2; b++) begin
      check("w16_valid", ov16, 1);
      check("w16_beat", beat16, b);
      check("w16_last", last16, (b == 1));
      check("w16_msg", msg16, model(v, 16, b));
      tick();
    end
    check("w16_idle", ov16, 0);
    check("w16_edge15_hand", model(v, 16, 1) ^ 48'h0, {1'b1, 5'(4 - OFS), {7{1'b0, 5'(4 - OFS)}}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cn_msg_expander.md
Name: cn_msg_expander

Overview:
- Check-node output stage of the min-sum LDPC decoder; the reverse direction of the 32-input min-finder.
- Accepts one compressed check-node result per handshake: min1, min2, the min1 position index, and the 32 input sign bits.
- Expands that result into Wc per-edge sign-magnitude messages.
- Streams the messages to the variable-node side in beats of P edges using valid/ready.

Parameters:
- W, 6, message width incl. sign; magnitude is W-1 bits.
- Wc, 32, check-node degree (edges per row); must be a multiple of P.
- P, 8, edges emitted per output beat; NBEATS = Wc/P.
- OFFSET, 1, offset subtracted from magnitudes when OFFSET_MS_EN is defined.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst, input, 1, synchronous active-low reset.
- in_valid, input, 1, compressed result present.
- in_ready, output, 1, block can accept a result this cycle.
- in_min1, input, W-1, smallest magnitude.
- in_min2, input, W-1, second-smallest magnitude.
- in_idx, input, 5, edge index of min1 (0..Wc-1).
- in_signs, input, Wc, sign bit of each incoming edge message; bit e = edge e.
- out_valid, output, 1, beat valid.
- out_ready, input, 1, downstream accepts beat.
- out_msg, output, P*W, P messages; slot j at [j*W +: W] is edge beat*P+j; bit W-1 = sign, [W-2:0] = magnitude.
- out_beat, output, 2, current beat number 0..NBEATS-1.
- out_last, output, 1, high on beat NBEATS-1.

Behaviour:
- Reset is synchronous: on any clk edge with rst=0, the block goes to IDLE, beat counter = 0, and out_valid = 0. Holding registers (min1, min2, idx, signs, parity) clear to 0. While in reset, in_ready = 0. An in-flight packet is dropped without completion.
- Output values while idle: out_msg = 0, out_beat = 0, out_last = 0.
- States:
  - IDLE: in_ready = 1. When in_valid=1, capture the inputs, compute parity = XOR of in_signs, and go to STREAM with beat = 0.
  - STREAM: out_valid = 1. On out_valid & out_ready with beat < NBEATS-1, beat increments by 1.
  - Last beat accepted (out_last & out_ready): if in_valid=1 in the same cycle, capture the new result and restart at beat 0. This is back-to-back operation with no bubble, and in_ready = out_last & out_ready in STREAM. Otherwise go to IDLE.
  - In STREAM before the last beat, in_ready = 0.
- Latency: a result accepted at edge N gives out_valid=1 with beat 0 in the cycle after edge N.
- Minimum packet duration is NBEATS cycles; maximum sustained rate is one result per NBEATS cycles.
- Per edge e:
  - sign = parity XOR signs[e] (extrinsic sign).
  - magnitude = (e == idx) ? min2 : min1.
- Output stability: out_msg, out_beat and out_last are functions of registered state only. They hold stable while out_valid=1 and out_ready=0 (stall of any length).
- idx >= Wc: no edge gets min2; all edges carry min1.
- min2 < min1 is not checked; values pass through as given.
- Zero magnitude still carries the computed sign bit.

Optional Feature:
- Macro OFFSET_MS_EN.
- Defined: each output magnitude becomes max(mag - OFFSET, 0), with unsigned saturation at 0; the sign is unchanged. Combinational, so latency is unchanged.
- Undefined: magnitudes are emitted raw and the OFFSET parameter is unused.

Test Plan:
- Reset/idle:
  - Stimulus: rst=0 for 3 cycles with in_valid=1 and out_ready=1.
  - Required: out_valid=0, in_ready=0, out_msg=0.
  - After rst=1: in_ready=1 and out_valid=0.
- Basic expand:
  - Stimulus: min1=3, min2=9, idx=10, signs=32'h0000_0401, out_ready=1.
  - Required: 4 consecutive beats, out_beat 0..3, out_last only on beat 3.
  - Parity=0, so edges 0 and 10 have sign 1 and all others sign 0.
  - Edge 10 (beat 1, slot 2) magnitude 9; all other edges magnitude 3.
- Odd parity:
  - Stimulus: signs=32'h0000_0001, min1=5, min2=7, idx=0.
  - Required: edge 0 = {0,7}; edges 1..31 = {1,5}.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during beat 2.
  - Required: out_msg and out_beat held constant and in_ready=0.
  - Beat 3 follows only after out_ready=1 is asserted.
- Back-to-back:
  - Stimulus: in_valid held high with two different results, out_ready=1.
  - Required: 8 consecutive valid beats with no gap.
  - The second packet is captured on the first packet's last-beat cycle.
- Mid-stream reset and out-of-range idx:
  - rst=0 during beat 1 → out_valid=0 next cycle; the next packet starts at beat 0.
  - idx=31 gives min2 on beat 3 slot 7; idx=31 with Wc=16 gives all min1.
  - With OFFSET_MS_EN and OFFSET=1: min1=0 → magnitude 0, min1=4 → magnitude 3.
